// File: rtl/cache_flush_generator_pkg.sv
// Shared definitions for the cache flush generator.
// Holds the one-hot FSM state type and helpers that derive the cache geometry
// (line count, set index width) from the cache parameters.
package PKG_CACHE;

    typedef enum logic [4:0] {
        ST_RESET   = 5'b00001,
        ST_READY   = 5'b00010,
        ST_ISSUE   = 5'b00100,
        ST_PENDING = 5'b01000,
        ST_DONE    = 5'b10000
    } cache_flush_generator_state;

    // Number of lines in the whole cache.
    function automatic int total_lines(input int cache_size, input int line_size_log);
        return cache_size >> line_size_log;
    endfunction

    // Width of the set index.
    function automatic int set_log(input int cache_size, input int line_size_log,
                                   input int num_ways);
        return $clog2(total_lines(cache_size, line_size_log) / num_ways);
    endfunction

endpackage

// File: rtl/cache_flush_addr_gen.sv
// Combinational request address generator.
// Ports:
//   line_idx - line counter c
//   mode     - 0 = linear sweep, 1 = way-alias conflict sweep
//   base     - sweep base address
//   addr     - resulting byte address (wraps modulo 2^ADDR_W)
module cache_flush_addr_gen
    import PKG_CACHE::*;
#(
    parameter int NUM_WAYS      = 4,
    parameter int LINE_SIZE_LOG = 6,
    parameter int CACHE_SIZE    = 65536,
    parameter int ADDR_W        = 64,
    parameter int COUNT_W       = 32
) (
    input  logic [COUNT_W-1:0] line_idx,
    input  logic               mode,
    input  logic [ADDR_W-1:0]  base,
    output logic [ADDR_W-1:0]  addr
);

    localparam int WAYS_LOG  = $clog2(NUM_WAYS);
    localparam int CACHE_LOG = $clog2(CACHE_SIZE);
    localparam logic [ADDR_W-1:0] WAY_MASK = ADDR_W'(NUM_WAYS - 1);

    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] way;
    logic [ADDR_W-1:0] set;

    always_comb begin
        idx = ADDR_W'(line_idx);
        way = idx & WAY_MASK;
        set = idx >> WAYS_LOG;
        // In conflict mode the way index selects a tag one cache-size apart,
        // so each set is hit by NUM_WAYS distinct tags back to back.
        if (mode) begin
            addr = base + (way << CACHE_LOG) + (set << LINE_SIZE_LOG);
        end else begin
            addr = base + (idx << LINE_SIZE_LOG);
        end
    end

endmodule

// File: rtl/cache_flush_generator.sv
// Cache flush generator: issues a sweep of line reads that evicts a cache,
// either linearly or by aliasing every way of each set.
// Ports:
//   ap_clk, ap_rst_n            - clock, synchronous active-low reset
//   start_in, mode_in           - start a sweep / select address pattern
//   base_address_in             - sweep base (latched at start)
//   line_count_in               - lines to touch, 0 = whole cache (latched)
//   abort_in                    - stop issuing, drain outstanding responses
//   req_valid_out/req_ready_in  - request handshake, req_addr_out address
//   resp_valid_in               - one response returned
//   busy_out, done_out          - not idle / one-cycle completion pulse
//   issued_count_out            - requests accepted in current/last sweep
//   resp_error_out              - sticky: response with nothing outstanding
//
// state   | meaning
// RESET   | first cycle after reset release
// READY   | idle, waiting for start_in
// ISSUE   | presenting requests
// PENDING | issuing finished, draining responses
// DONE    | one-cycle completion pulse
module cache_flush_generator
    import PKG_CACHE::*;
#(
    parameter int NUM_WAYS        = 4,
    parameter int LINE_SIZE_LOG   = 6,
    parameter int CACHE_SIZE      = 65536,
    parameter int ADDR_W          = 64,
    parameter int MAX_OUTSTANDING = 16,
    parameter int COUNT_W         = 32
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               start_in,
    input  logic               mode_in,
    input  logic [ADDR_W-1:0]  base_address_in,
    input  logic [COUNT_W-1:0] line_count_in,
    input  logic               abort_in,
    output logic               req_valid_out,
    input  logic               req_ready_in,
    output logic [ADDR_W-1:0]  req_addr_out,
    input  logic               resp_valid_in,
    output logic               busy_out,
    output logic               done_out,
    output logic [COUNT_W-1:0] issued_count_out,
    output logic               resp_error_out
);

    localparam int TOTAL = total_lines(CACHE_SIZE, LINE_SIZE_LOG);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [COUNT_W-1:0] TOTAL_C = COUNT_W'(TOTAL);
    localparam logic [OUT_W-1:0]   MAX_OUT = OUT_W'(MAX_OUTSTANDING);

    cache_flush_generator_state state, state_nxt;

    logic [COUNT_W-1:0] line_cnt, line_cnt_nxt;
    logic [COUNT_W-1:0] n_lines, n_lines_nxt;
    logic [COUNT_W-1:0] issued, issued_nxt;
    logic [OUT_W-1:0]   outstanding, outstanding_nxt;
    logic [ADDR_W-1:0]  base_q, base_nxt;
    logic               mode_q, mode_nxt;
    logic               req_valid, valid_nxt;
    logic [ADDR_W-1:0]  req_addr, addr_nxt;
    logic               resp_error, error_nxt;
    logic               accept;
    logic               resp_ok;

    always_comb begin
        state_nxt    = state;
        line_cnt_nxt = line_cnt;
        n_lines_nxt  = n_lines;
        issued_nxt   = issued;
        base_nxt     = base_q;
        mode_nxt     = mode_q;
        error_nxt    = resp_error;

        accept  = req_valid & req_ready_in;
        resp_ok = resp_valid_in & (outstanding != '0);
        if (resp_valid_in && outstanding == '0) begin
            error_nxt = 1'b1;
        end
        outstanding_nxt = outstanding + OUT_W'(accept) - OUT_W'(resp_ok);

        if (accept) begin
            line_cnt_nxt = line_cnt + 1'b1;
            issued_nxt   = issued + 1'b1;
        end

        case (state)
            ST_RESET: state_nxt = ST_READY;
            ST_READY: begin
                if (start_in) begin
                    state_nxt    = ST_ISSUE;
                    line_cnt_nxt = '0;
                    issued_nxt   = '0;
                    error_nxt    = 1'b0;
                    base_nxt     = base_address_in;
                    mode_nxt     = mode_in;
                    n_lines_nxt  = (line_count_in == '0 || line_count_in > TOTAL_C) ?
                                   TOTAL_C : line_count_in;
                end
            end
            ST_ISSUE: begin
                if (abort_in || (accept && line_cnt_nxt == n_lines)) begin
                    state_nxt = ST_PENDING;
                end
            end
            // Looking at the post-update count lets DONE follow the final
            // response by a single cycle.
            ST_PENDING: if (outstanding_nxt == '0) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_READY;
            default:    state_nxt = ST_RESET;
        endcase

        valid_nxt = (state_nxt == ST_ISSUE) && (line_cnt_nxt < n_lines_nxt) &&
                    !abort_in && (outstanding_nxt < MAX_OUT);
    end

    // The address follows the next counter value, so it is stable during a
    // stall and advances with no bubble after an accept.
    cache_flush_addr_gen #(
        .NUM_WAYS      (NUM_WAYS),
        .LINE_SIZE_LOG (LINE_SIZE_LOG),
        .CACHE_SIZE    (CACHE_SIZE),
        .ADDR_W        (ADDR_W),
        .COUNT_W       (COUNT_W)
    ) u_addr_gen (
        .line_idx (line_cnt_nxt),
        .mode     (mode_nxt),
        .base     (base_nxt),
        .addr     (addr_nxt)
    );

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state       <= ST_RESET;
            line_cnt    <= '0;
            n_lines     <= '0;
            issued      <= '0;
            outstanding <= '0;
            base_q      <= '0;
            mode_q      <= 1'b0;
            req_valid   <= 1'b0;
            req_addr    <= '0;
            resp_error  <= 1'b0;
        end else begin
            state       <= state_nxt;
            line_cnt    <= line_cnt_nxt;
            n_lines     <= n_lines_nxt;
            issued      <= issued_nxt;
            outstanding <= outstanding_nxt;
            base_q      <= base_nxt;
            mode_q      <= mode_nxt;
            req_valid   <= valid_nxt;
            req_addr    <= addr_nxt;
            resp_error  <= error_nxt;
        end
    end

    assign req_valid_out    = req_valid;
    assign req_addr_out     = req_addr;
    assign issued_count_out = issued;
    assign resp_error_out   = resp_error;
    assign done_out         = (state == ST_DONE);
    // Gated by reset so the output reads 0 while reset is held.
    assign busy_out         = ap_rst_n & (state != ST_READY);

endmodule

// File: tb/tb_cache_flush_generator.sv
module tb_cache_flush_generator;

    localparam int TOTAL = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start, mode, abort;
    logic [63:0] base;
    logic [31:0] count;
    logic        ready_in, ready_man, ready_rnd, rand_ready;
    logic        resp_in, auto_resp, man_resp;
    logic        valid, busy, done, err;
    logic [63:0] addr;
    logic [31:0] issued;

    logic        start2, ready2, resp2;
    logic        valid2, busy2, done2, err2;
    logic [63:0] addr2;
    logic [31:0] issued2;

    assign ready_in = rand_ready ? ready_rnd : ready_man;
    assign resp_in  = auto_resp | man_resp;

    always #5 clk = ~clk;

    cache_flush_generator #(
        .NUM_WAYS(4), .LINE_SIZE_LOG(6), .CACHE_SIZE(1024), .ADDR_W(64),
        .MAX_OUTSTANDING(16), .COUNT_W(32)
    ) dut (
        .ap_clk(clk), .ap_rst_n(rst_n), .start_in(start), .mode_in(mode),
        .base_address_in(base), .line_count_in(count), .abort_in(abort),
        .req_valid_out(valid), .req_ready_in(ready_in), .req_addr_out(addr),
        .resp_valid_in(resp_in), .busy_out(busy), .done_out(done),
        .issued_count_out(issued), .resp_error_out(err)
    );

    cache_flush_generator #(
        .NUM_WAYS(4), .LINE_SIZE_LOG(6), .CACHE_SIZE(1024), .ADDR_W(64),
        .MAX_OUTSTANDING(2), .COUNT_W(32)
    ) dut2 (
        .ap_clk(clk), .ap_rst_n(rst_n), .start_in(start2), .mode_in(mode),
        .base_address_in(base), .line_count_in(count), .abort_in(abort),
        .req_valid_out(valid2), .req_ready_in(ready2), .req_addr_out(addr2),
        .resp_valid_in(resp2), .busy_out(busy2), .done_out(done2),
        .issued_count_out(issued2), .resp_error_out(err2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc, done_cnt, done_cyc, resp_cyc;
    int delay_min = 2, delay_max = 2;
    bit resp_hold = 0;
    logic [63:0] got_q[$];
    int acc_cyc[$];
    int due_q[$];
    bit stalled_prev = 0;
    logic [63:0] held_addr;

    typedef struct {
        bit          m;
        logic [63:0] b;
        logic [31:0] cnt;
        int          n;
        logic [63:0] last;
    } vec_t;
    vec_t vecs[8];

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: address of line c from the cache geometry (4 ways, 64 B lines, 1 KiB).
    function automatic logic [63:0] exp_addr(bit m, logic [63:0] b, int c);
        if (!m) return b + 64'(c) * 64;
        return b + 64'(c % 4) * 1024 + 64'(c / 4) * 64;
    endfunction

    // Cycle counter, random ready and delayed responses (one per cycle at most).
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        ready_rnd = ($urandom_range(3) != 0);
        auto_resp = 1'b0;
        if (!resp_hold) begin
            for (int i = 0; i < due_q.size(); i++) begin
                if (due_q[i] <= cyc) begin
                    due_q.delete(i);
                    auto_resp = 1'b1;
                    break;
                end
            end
        end
    end

    // Monitor on the main DUT.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (stalled_prev && valid) check("stall_addr", addr, held_addr);
            stalled_prev = valid && !ready_in;
            held_addr = addr;
            if (valid && ready_in) begin
                got_q.push_back(addr);
                acc_cyc.push_back(cyc);
                due_q.push_back(cyc + int'($urandom_range(delay_max, delay_min)));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (resp_in) resp_cyc = cyc;
        end else begin
            stalled_prev = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic start_sweep(bit m, logic [63:0] b, logic [31:0] cnt);
        got_q.delete();
        acc_cyc.delete();
        done_cnt = 0;
        @(posedge clk); #1;
        mode = m; base = b; count = cnt; start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        // Scramble inputs to show they were latched at start.
        start = 1'b0; mode = ~m; base = ~b; count = 32'd3;
    endtask

    task automatic finish_sweep(string tag, bit m, logic [63:0] b, logic [31:0] cnt, bit b2b);
        int n, w;
        n = (cnt == 0 || cnt > 32'(TOTAL)) ? TOTAL : int'(cnt);
        w = 0;
        while (done_cnt == 0 && w < 3000) begin
            @(posedge clk);
            w++;
        end
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: done_out not seen after %0d cycles", tag, w);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({tag, "_len"}, 64'(got_q.size()), 64'(n));
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_issued"}, 64'(issued), 64'(n));
        check({tag, "_busy_idle"}, 64'(busy), 64'd0);
        for (int i = 0; i < got_q.size() && i < n; i++)
            check($sformatf("%s_addr%0d", tag, i), got_q[i], exp_addr(m, b, i));
        if (b2b && got_q.size() == n) begin
            check({tag, "_first_latency"}, 64'(acc_cyc[0]), 64'(start_cyc + 1));
            check({tag, "_back_to_back"}, 64'(acc_cyc[n-1] - acc_cyc[0]), 64'(n - 1));
        end
    endtask

    initial begin
        int w, acc2;
        start = 0; mode = 0; abort = 0; base = '0; count = '0;
        ready_man = 1; rand_ready = 0; man_resp = 0; auto_resp = 0; ready_rnd = 1;
        start2 = 0; ready2 = 0; resp2 = 0;

        vecs[0] = '{1'b0, 64'h1000, 32'd0, 16, 64'h13C0};
        vecs[1] = '{1'b1, 64'h0, 32'd0, 16, 64'hCC0};
        vecs[2] = '{1'b0, 64'h2000, 32'd5, 5, 64'h2100};
        vecs[3] = '{1'b0, 64'h0, 32'd17, 16, 64'h3C0};
        vecs[4] = '{1'b1, 64'h100, 32'd6, 6, 64'h540};
        vecs[5] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFC0, 32'd2, 2, 64'h0};
        vecs[6] = '{1'b1, 64'h0, 32'd1, 1, 64'h0};
        vecs[7] = '{1'b1, 64'hFFFF_FFFF_FFFF_F800, 32'd4, 4, 64'h400};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_addr", addr, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_issued", 64'(issued), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(posedge clk); #1; rst_n = 1;
        @(negedge clk);
        check("reset_state_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("ready_state_busy", 64'(busy), 64'd0);

        // Table-driven sweeps, ready always high, response 2 cycles after accept
        for (int i = 0; i < 8; i++) begin
            start_sweep(vecs[i].m, vecs[i].b, vecs[i].cnt);
            finish_sweep($sformatf("vec%0d", i), vecs[i].m, vecs[i].b, vecs[i].cnt, 1'b1);
            check($sformatf("vec%0d_count", i), 64'(got_q.size()), 64'(vecs[i].n));
            if (got_q.size() > 0) begin
                check($sformatf("vec%0d_last", i), got_q[got_q.size()-1], vecs[i].last);
            end else begin
                checks++;
                errors++;
                $display("FAIL vec%0d_last: no request accepted, expected last 0x%0h", i, vecs[i].last);
            end
        end

        // Stall on the third request
        start_sweep(1'b0, 64'h1000, 32'd0);
        w = 0;
        while (got_q.size() < 2 && w < 100) begin
            @(negedge clk); #1;
            w++;
        end
        @(posedge clk); #1; ready_man = 0;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", 64'(valid), 64'd1);
            check("stall_addr_1080", addr, 64'h1080);
            @(posedge clk); #1;
        end
        ready_man = 1;
        finish_sweep("stall", 1'b0, 64'h1000, 32'd0, 1'b0);

        // Abort after 5 accepts with 5 outstanding
        resp_hold = 1;
        start_sweep(1'b0, 64'h1000, 32'd0);
        w = 0;
        while (got_q.size() < 5 && w < 100) begin
            @(negedge clk); #1;
            w++;
        end
        @(posedge clk); #1; abort = 1; ready_man = 0;
        @(posedge clk); #1; abort = 0; ready_man = 1;
        repeat (4) begin
            @(negedge clk);
            check("abort_no_valid", 64'(valid), 64'd0);
        end
        resp_hold = 0;
        w = 0;
        while (done_cnt == 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        @(negedge clk);
        check("abort_done_seen", 64'(done_cnt), 64'd1);
        check("abort_done_latency", 64'(done_cyc), 64'(resp_cyc + 1));
        check("abort_accepts", 64'(got_q.size()), 64'd5);
        check("abort_issued", 64'(issued), 64'd5);

        // Outstanding limit of 2 on the second instance
        @(posedge clk); #1; mode = 0; base = 64'h0; count = 0; start2 = 1; ready2 = 1;
        @(posedge clk); #1; start2 = 0;
        acc2 = 0;
        repeat (10) begin
            @(negedge clk);
            if (valid2 && ready2) acc2++;
        end
        check("maxout_accepts", 64'(acc2), 64'd2);
        check("maxout_valid_low", 64'(valid2), 64'd0);
        @(posedge clk); #1; resp2 = 1;
        @(posedge clk); #1; resp2 = 0;
        acc2 = 0;
        repeat (10) begin
            @(negedge clk);
            if (valid2 && ready2) acc2++;
        end
        check("maxout_after_resp", 64'(acc2), 64'd1);
        check("maxout_issued", 64'(issued2), 64'd3);

        // Randomized sweeps against the model
        rand_ready = 1; delay_min = 1; delay_max = 5;
        for (int i = 0; i < 6; i++) begin
            bit m;
            logic [63:0] b;
            logic [31:0] c;
            m = 1'($urandom_range(1));
            b = {$urandom, $urandom};
            c = 32'($urandom_range(20));
            start_sweep(m, b, c);
            finish_sweep($sformatf("rnd%0d", i), m, b, c, 1'b0);
        end
        rand_ready = 0; delay_min = 2; delay_max = 2;

        // Spurious response sets the sticky error until the next start
        @(posedge clk); #1; man_resp = 1;
        @(posedge clk); #1; man_resp = 0;
        @(negedge clk);
        check("spurious_err", 64'(err), 64'd1);
        repeat (3) @(negedge clk);
        check("spurious_err_sticky", 64'(err), 64'd1);
        start_sweep(1'b0, 64'h1000, 32'd0);
        @(negedge clk);
        check("start_err_clear", 64'(err), 64'd0);
        check("start_issued_clear", 64'(issued), 64'd0);
        check("start_first_valid", 64'(valid), 64'd1);
        check("start_first_addr", addr, 64'h1000);

        // Reset mid-sweep
        repeat (3) @(posedge clk);
        #1; rst_n = 0; resp_hold = 1; due_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", 64'(valid), 64'd0);
        check("midrst_addr", addr, 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_issued", 64'(issued), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        @(posedge clk); #1; rst_n = 1; resp_hold = 0;
        @(negedge clk);
        check("midrst_reset_busy", 64'(busy), 64'd1);
        check("midrst_reset_valid", 64'(valid), 64'd0);
        @(negedge clk);
        check("midrst_ready_busy", 64'(busy), 64'd0);
        check("midrst_ready_err", 64'(err), 64'd0);
        @(posedge clk); #1; man_resp = 1;
        @(posedge clk); #1; man_resp = 0;
        @(negedge clk);
        check("late_resp_err", 64'(err), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
